store_checker: RTL
==================

Name: store_checker

Overview:
- Synthesizable, parametrised store-sequence checker.
- Watches the processor data-memory write port (memwrite, dataaddr, writedata) and compares each store against a programmed table of DEPTH expected (address, data) pairs, in order.
- Scratch-address stores are ignored. A timeout is enforced, and pass/fail status is latched with diagnostic capture.
- Sits beside the processor top level so benches and FPGA builds share one checker instead of hand-coded compare logic.

Parameters:
- WIDTH, 32: address and data width.
- DEPTH, 4: number of expected stores; minimum 1.
- TIMEOUT, 1024: cycles allowed in RUN before a timeout failure; minimum 2.
- IGNORE_EN, 1: when 1, stores to IGNORE_ADDR are skipped.
- IGNORE_ADDR, 80: scratch address tolerated between expected stores.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- memwrite  in  1  store strobe from the processor.
- dataaddr  in  WIDTH  store address.
- writedata  in  WIDTH  store data.
- exp_we  in  1  table write enable; honoured only in IDLE.
- exp_idx  in  max(1,$clog2(DEPTH))  table entry index.
- exp_addr  in  WIDTH  expected address for entry exp_idx.
- exp_data  in  WIDTH  expected data for entry exp_idx.
- start  in  1  begin (or restart) checking.
- busy  out  1  state is RUN.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state is PASS.
- fail  out  1  state is FAIL.
- fail_code  out  2  0 none, 1 mismatch, 2 timeout.
- match_count  out  $clog2(DEPTH+1)  expected stores matched so far.
- fail_addr  out  WIDTH  dataaddr of the offending store; 0 on timeout.
- fail_data  out  WIDTH  writedata of the offending store; 0 on timeout.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state goes to IDLE.
  - All outputs go to 0: busy, done, pass, fail, fail_code, match_count, fail_addr, fail_data.
  - Internal ptr and cycle counter go to 0.
  - Table contents are not reset; they are retained.
  - Reset mid-RUN aborts the run with no fail flag.
- IDLE:
  - exp_we=1 writes the table entry at exp_idx; exp_idx >= DEPTH is ignored.
  - start=1 moves to RUN and clears ptr, counter, match_count and the fail_* outputs.
  - If exp_we and start are high in the same cycle, the write completes and the run starts the next cycle.
- RUN, on a cycle with memwrite=1, priority as follows:
  - (a) dataaddr==table[ptr].addr and writedata==table[ptr].data: ptr and match_count increment. If ptr was DEPTH-1, go to PASS.
  - (b) Otherwise, IGNORE_EN and dataaddr==IGNORE_ADDR: no change. An expected entry whose address equals IGNORE_ADDR but whose data mismatches is treated as ignored, not failed.
  - (c) Otherwise: go to FAIL with fail_code=1, and capture dataaddr and writedata into fail_addr/fail_data.
- RUN, cycles with memwrite=0 or memwrite=X: no compare.
- RUN, timeout:
  - The counter increments every RUN cycle.
  - When the counter reaches TIMEOUT-1 and no transition has occurred that cycle, go to FAIL with fail_code=2.
- Simultaneous events in RUN:
  - Final match plus timeout in the same cycle: PASS.
  - Mismatch plus timeout in the same cycle: fail_code=1.
  - start while in RUN is ignored. exp_we while not in IDLE is ignored.
- PASS/FAIL:
  - Outputs hold; further memwrite activity is ignored.
  - start=1 returns to RUN with a clear, same as from IDLE.
- Latency:
  - All outputs are registered and reflect a store the cycle after the edge at which it is sampled.
  - An n-store run passes, at the earliest, n cycles after entering RUN.
- Widths:
  - Compares are exact WIDTH-bit equality.
  - The counter is $clog2(TIMEOUT) bits and does not wrap, because RUN exits at TIMEOUT-1.

Decomposition:
- Package store_checker_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, PASS=2'd2, FAIL=2'd3.
  - Fail codes: FC_NONE=0, FC_MISMATCH=1, FC_TIMEOUT=2.
- Sub-module store_table:
  - DEPTH x (2*WIDTH) register file.
  - One synchronous write port (we, idx, addr, data).
  - One combinational read port indexed by ptr.
- The FSM, counter and capture registers stay in store_checker.

Test Plan:
- DEPTH=2, table {(84,7),(88,9)}, start, then stores (80,3),(84,7),(80,1),(88,9) → pass=1, match_count=2, fail_code=0, busy=0.
- Table {(84,7),(88,9)}, store (84,6) → fail=1, fail_code=1, fail_addr=84, fail_data=6, match_count=0.
- TIMEOUT=16, start, no stores → fail=1 and fail_code=2 exactly 16 cycles after busy rises; fail_addr=0.
- DEPTH=1, TIMEOUT=4, final matching store on the timeout cycle → pass=1, fail=0.
- reset=0 mid-RUN after one match, then start without reprogramming → match_count cleared to 0, table retained, sequence then passes.
- exp_we in RUN with entry 0 set to (100,1) → ignored; the original (84,7) still matches.

Source files
------------

// File: rtl/store_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module  : store_checker_pkg
// Brief   : Shared state/fail-code encodings and width helper for store_checker.
// Revision: 1.0
// ============================================================================
package store_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fail_code_e;

    // Index width for a table of the given depth; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_checker_if.sv
`default_nettype none
// ============================================================================
// Module  : store_checker_if
// Brief   : Store port, table programming and status bundle of store_checker.
// Revision: 1.0
// ============================================================================
interface store_checker_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    import store_checker_pkg::*;

    localparam int IDXW = idx_width(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic             memwrite;
    logic [WIDTH-1:0] dataaddr;
    logic [WIDTH-1:0] writedata;
    logic             exp_we;
    logic [IDXW-1:0]  exp_idx;
    logic [WIDTH-1:0] exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [CNTW-1:0]  match_count;
    logic [WIDTH-1:0] fail_addr;
    logic [WIDTH-1:0] fail_data;

    modport master (
        output memwrite, dataaddr, writedata, exp_we, exp_idx, exp_addr, exp_data, start,
        input  busy, done, pass, fail, fail_code, match_count, fail_addr, fail_data
    );

    modport slave (
        input  memwrite, dataaddr, writedata, exp_we, exp_idx, exp_addr, exp_data, start,
        output busy, done, pass, fail, fail_code, match_count, fail_addr, fail_data
    );

endinterface
`default_nettype wire

// File: rtl/store_checker_table.sv
`default_nettype none
// ============================================================================
// Module  : store_table
// Brief   : DEPTH-entry (address, data) register file, one write, one read port.
// Revision: 1.0
// ============================================================================
module store_table #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  wire logic             clk,
    input  wire logic             we_i,
    input  wire logic [IDXW-1:0]  idx_i,
    input  wire logic [WIDTH-1:0] addr_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic [IDXW-1:0]  rd_idx_i,
    output logic      [WIDTH-1:0] rd_addr_o,
    output logic      [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    // Contents survive reset so a run can be restarted without reprogramming.
    always_ff @(posedge clk) begin
        if (we_i && (int'(idx_i) < DEPTH)) begin
            addr_q[idx_i] <= addr_i;
            data_q[idx_i] <= data_i;
        end
    end

    assign rd_addr_o = addr_q[rd_idx_i];
    assign rd_data_o = data_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/store_checker.sv
`default_nettype none
// ============================================================================
// Module  : store_checker
// Brief   : Compares processor stores against a programmed ordered table.
// Revision: 1.0
// ============================================================================
module store_checker
    import store_checker_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 1024,
    parameter int IGNORE_EN   = 1,
    parameter int IGNORE_ADDR = 80
) (
    input wire logic       clk,
    input wire logic       reset,
    store_checker_if.slave bus
);

    localparam int IDXW  = idx_width(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] IGN_ADDR = WIDTH'(IGNORE_ADDR);
    localparam logic [IDXW-1:0]  PTR_LAST = IDXW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNTW-1:0]  match_q, match_d;
    fail_code_e       fcode_q, fcode_d;
    logic [WIDTH-1:0] faddr_q, faddr_d;
    logic [WIDTH-1:0] fdata_q, fdata_d;
    logic             busy_q, done_q, pass_q, fail_q;

    logic [WIDTH-1:0] exp_addr_w, exp_data_w;
    logic             hit_w, ignore_w;

    store_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDXW  (IDXW)
    ) u_table (
        .clk       (clk),
        .we_i      (bus.exp_we && (state_q == IDLE)),
        .idx_i     (bus.exp_idx),
        .addr_i    (bus.exp_addr),
        .data_i    (bus.exp_data),
        .rd_idx_i  (ptr_q),
        .rd_addr_o (exp_addr_w),
        .rd_data_o (exp_data_w)
    );

    assign hit_w    = (bus.dataaddr == exp_addr_w) && (bus.writedata == exp_data_w);
    assign ignore_w = (IGNORE_EN != 0) && (bus.dataaddr == IGN_ADDR);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        fcode_d = fcode_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.memwrite) begin
                    if (hit_w) begin
                        match_d = match_q + 1'b1;
                        if (ptr_q == PTR_LAST) state_d = PASS;
                        else                   ptr_d   = ptr_q + 1'b1;
                    end else if (!ignore_w) begin
                        state_d = FAIL;
                        fcode_d = FC_MISMATCH;
                        faddr_d = bus.dataaddr;
                        fdata_d = bus.writedata;
                    end
                end
                // A store-driven transition on the last cycle takes precedence.
                if ((state_d == RUN) && (cnt_q == CNT_LAST)) begin
                    state_d = FAIL;
                    fcode_d = FC_TIMEOUT;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
            default: begin
                if (bus.start) begin
                    state_d = RUN;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    match_d = '0;
                    fcode_d = FC_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            match_q <= '0;
            fcode_q <= FC_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            fcode_q <= fcode_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == PASS) || (state_d == FAIL);
            pass_q  <= (state_d == PASS);
            fail_q  <= (state_d == FAIL);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.fail_code   = fcode_q;
    assign bus.match_count = match_q;
    assign bus.fail_addr   = faddr_q;
    assign bus.fail_data   = fdata_q;

endmodule
`default_nettype wire
